// File: rtl/board_cursor_controller.sv
// Chess board cursor controller: per-button synchroniser and debouncer,
// press/auto-repeat FSM, edge-aware row/column update and seven-segment
// decode of the current coordinates.
module board_cursor_controller #(
  parameter int unsigned COORD_W         = 3,
  parameter int unsigned BOARD_SIZE      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 5,
  parameter int unsigned WRAP            = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               UP,
  input  logic               DOWN,
  input  logic               LEFT,
  input  logic               RIGHT,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               moved,
  output logic [6:0]         segments1,
  output logic [6:0]         segments2
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RC_W    = $clog2(RPT_MAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRE   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_REPEAT = 2'd3;

  // Button index: 0 = UP, 1 = DOWN, 2 = LEFT, 3 = RIGHT
  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      level;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      flip;
  logic [3:0]      rise;
  logic [3:0]      fall;
  logic [1:0]      state [4];
  logic [RC_W-1:0] rpt_cnt [4];
  logic [3:0]      step;

  logic [COORD_W-1:0] row_nxt;
  logic [COORD_W-1:0] col_nxt;

  // Gather the raw buttons into one vector
  always_comb begin
    raw = {RIGHT, LEFT, DOWN, UP};
  end

  // Two-flop synchroniser and debounce counter per button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES)) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced edge events, aligned with the edge that flips the level so
  // the FSM enters FIRE in the same cycle the debounced level rises
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      flip[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES));
    end
    rise = flip & ~level;
    fall = flip & level;
  end

  // Step requests decoded from FSM state and repeat counter
  always_comb begin
    step = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!fall[i]) begin
        case (state[i])
          ST_FIRE:   step[i] = 1'b1;
          ST_HOLD:   step[i] = (REPEAT_DELAY != 0) &&
                               (rpt_cnt[i] == RC_W'(REPEAT_DELAY - 1));
          ST_REPEAT: step[i] = (rpt_cnt[i] == RC_W'(REPEAT_RATE - 1));
          default:   step[i] = 1'b0;
        endcase
      end
    end
  end

  // Per-button press / hold / auto-repeat FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i]   <= ST_IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (fall[i]) begin
          state[i]   <= ST_IDLE;
          rpt_cnt[i] <= '0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              rpt_cnt[i] <= '0;
              if (rise[i]) state[i] <= ST_FIRE;
            end
            ST_FIRE: begin
              state[i]   <= ST_HOLD;
              rpt_cnt[i] <= '0;
            end
            ST_HOLD: begin
              if (step[i]) begin
                state[i]   <= ST_REPEAT;
                rpt_cnt[i] <= '0;
              end else if (REPEAT_DELAY != 0) begin
                rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
              end
            end
            default: begin
              if (step[i]) rpt_cnt[i] <= '0;
              else         rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
            end
          endcase
        end
      end
    end
  end

  // One-axis update; the extra MSB turns both overflow and 0-1 underflow
  // into an out-of-range value caught by a single compare
  function automatic logic [COORD_W-1:0] axis_next(
    input logic [COORD_W-1:0] cur,
    input logic               inc,
    input logic               dec
  );
    logic [COORD_W:0] ext;
    axis_next = cur;
    ext       = '0;
    if (inc ^ dec) begin
      if (inc) ext = {1'b0, cur} + (COORD_W+1)'(1);
      else     ext = {1'b0, cur} - (COORD_W+1)'(1);
      if (ext < (COORD_W+1)'(BOARD_SIZE)) begin
        axis_next = ext[COORD_W-1:0];
      end else if (WRAP != 0) begin
        axis_next = inc ? '0 : COORD_W'(BOARD_SIZE - 1);
      end
    end
  endfunction

  // Next cursor position from the combined step requests
  always_comb begin
    row_nxt = axis_next(row, step[0], step[1]);
    col_nxt = axis_next(col, step[3], step[2]);
  end

  // Cursor registers and change pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      row   <= '0;
      col   <= '0;
      moved <= 1'b0;
    end else begin
      row   <= row_nxt;
      col   <= col_nxt;
      moved <= (row_nxt != row) || (col_nxt != col);
    end
  end

  // Seven-segment decode, bit order {g,f,e,d,c,b,a}, active high
  function automatic logic [6:0] sevenseg(input logic [3:0] v);
    case (v)
      4'h0:    sevenseg = 7'b0111111;
      4'h1:    sevenseg = 7'b0000110;
      4'h2:    sevenseg = 7'b1011011;
      4'h3:    sevenseg = 7'b1001111;
      4'h4:    sevenseg = 7'b1100110;
      4'h5:    sevenseg = 7'b1101101;
      4'h6:    sevenseg = 7'b1111101;
      4'h7:    sevenseg = 7'b0000111;
      4'h8:    sevenseg = 7'b1111111;
      4'h9:    sevenseg = 7'b1101111;
      4'hA:    sevenseg = 7'b1110111;
      4'hB:    sevenseg = 7'b1111100;
      4'hC:    sevenseg = 7'b0111001;
      4'hD:    sevenseg = 7'b1011110;
      4'hE:    sevenseg = 7'b1111001;
      default: sevenseg = 7'b1110001;
    endcase
  endfunction

  // Coordinate digits for the displays
  always_comb begin
    segments1 = sevenseg(4'(row));
    segments2 = sevenseg(4'(col));
  end

endmodule

// File: tb/tb_board_cursor_controller.sv
// Directed bench for board_cursor_controller using three configurations:
// A = no repeat / saturate, B = no repeat / wrap, C = repeat / saturate.
module tb_board_cursor_controller;

  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;
  localparam logic [6:0] SEG5 = 7'b1101101;
  localparam logic [6:0] SEG7 = 7'b0000111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_a, btn_b, btn_c; // {RIGHT, LEFT, DOWN, UP}

  logic [2:0] row_a, col_a, row_b, col_b, row_c, col_c;
  logic       moved_a, moved_b, moved_c;
  logic [6:0] s1_a, s2_a, s1_b, s2_b, s1_c, s2_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  board_cursor_controller #(.COORD_W(3), .BOARD_SIZE(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(0), .REPEAT_RATE(5), .WRAP(0)) dut_a (
    .clk(clk), .reset(reset), .UP(btn_a[0]), .DOWN(btn_a[1]), .LEFT(btn_a[2]),
    .RIGHT(btn_a[3]), .row(row_a), .col(col_a), .moved(moved_a),
    .segments1(s1_a), .segments2(s2_a));

  board_cursor_controller #(.COORD_W(3), .BOARD_SIZE(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(0), .REPEAT_RATE(5), .WRAP(1)) dut_b (
    .clk(clk), .reset(reset), .UP(btn_b[0]), .DOWN(btn_b[1]), .LEFT(btn_b[2]),
    .RIGHT(btn_b[3]), .row(row_b), .col(col_b), .moved(moved_b),
    .segments1(s1_b), .segments2(s2_b));

  board_cursor_controller #(.COORD_W(3), .BOARD_SIZE(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(0)) dut_c (
    .clk(clk), .reset(reset), .UP(btn_c[0]), .DOWN(btn_c[1]), .LEFT(btn_c[2]),
    .RIGHT(btn_c[3]), .row(row_c), .col(col_c), .moved(moved_c),
    .segments1(s1_c), .segments2(s2_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d, input logic [3:0] m);
    if (d == 0) btn_a = m; else btn_b = m;
    repeat (12) tick();
    btn_a = '0;
    btn_b = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_a = '0; btn_b = '0; btn_c = '0;
    repeat (3) tick();
    reset = 1'b0;
    total++; if (row_a !== 3'd0) begin bad++; $display("FAIL reset_row_a: got %0d want 0", row_a); end
    total++; if (col_a !== 3'd0) begin bad++; $display("FAIL reset_col_a: got %0d want 0", col_a); end
    total++; if (moved_a !== 1'b0) begin bad++; $display("FAIL reset_moved_a: got %b want 0", moved_a); end
    total++; if (s1_a !== SEG0) begin bad++; $display("FAIL reset_seg1_a: got %b want %b", s1_a, SEG0); end
    total++; if (s2_a !== SEG0) begin bad++; $display("FAIL reset_seg2_a: got %b want %b", s2_a, SEG0); end
    total++; if (row_b !== 3'd0 || row_c !== 3'd0) begin bad++; $display("FAIL reset_row_bc: got %0d/%0d want 0/0", row_b, row_c); end
  endtask

  task automatic test_press();
    int pulses = 0;
    btn_a = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (moved_a) pulses++;
      if (k == 7) begin
        total++; if (row_a !== 3'd0) begin bad++; $display("FAIL press_early: got %0d want 0", row_a); end
      end
      if (k == 8) begin
        total++; if (row_a !== 3'd1 || moved_a !== 1'b1) begin bad++; $display("FAIL press_latency: got row=%0d moved=%b want row=1 moved=1", row_a, moved_a); end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL press_pulses: got %0d want 1", pulses); end
    total++; if (s1_a !== SEG1) begin bad++; $display("FAIL press_seg1: got %b want %b", s1_a, SEG1); end
    total++; if (col_a !== 3'd0) begin bad++; $display("FAIL press_col: got %0d want 0", col_a); end
    btn_a = '0;
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    int pulses = 0;
    btn_a = 4'b1000;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 3) btn_a = '0;
      if (moved_a) pulses++;
    end
    total++; if (col_a !== 3'd0) begin bad++; $display("FAIL glitch_col: got %0d want 0", col_a); end
    total++; if (pulses != 0) begin bad++; $display("FAIL glitch_moved: got %0d want 0", pulses); end
  endtask

  task automatic test_edge();
    int pa = 0;
    int pb = 0;
    // A: 1 -> 0, then a second DOWN press at 0 must be ignored
    btn_a = 4'b0010;
    repeat (30) begin tick(); if (moved_a) pa++; end
    total++; if (row_a !== 3'd0 || pa != 1) begin bad++; $display("FAIL edge_down_to0: got row=%0d pulses=%0d want row=0 pulses=1", row_a, pa); end
    btn_a = '0;
    repeat (10) tick();
    pa = 0;
    btn_a = 4'b0010;
    repeat (30) begin tick(); if (moved_a) pa++; end
    total++; if (row_a !== 3'd0) begin bad++; $display("FAIL edge_sat_row: got %0d want 0", row_a); end
    total++; if (pa != 0) begin bad++; $display("FAIL edge_sat_moved: got %0d want 0", pa); end
    btn_a = '0;
    repeat (10) tick();
    // B wraps 0 -> 7
    btn_b = 4'b0010;
    repeat (30) begin tick(); if (moved_b) pb++; end
    total++; if (row_b !== 3'd7) begin bad++; $display("FAIL edge_wrap_row: got %0d want 7", row_b); end
    total++; if (pb != 1) begin bad++; $display("FAIL edge_wrap_moved: got %0d want 1", pb); end
    total++; if (s1_b !== SEG7) begin bad++; $display("FAIL edge_wrap_seg1: got %b want %b", s1_b, SEG7); end
    btn_b = '0;
    repeat (10) tick();
  endtask

  task automatic test_repeat();
    int pulses = 0;
    btn_c = 4'b0001;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (moved_c) pulses++;
      if (k == 8) begin
        total++; if (row_c !== 3'd1) begin bad++; $display("FAIL repeat_fire: got %0d want 1", row_c); end
      end
      if (k == 27) begin
        total++; if (row_c !== 3'd1) begin bad++; $display("FAIL repeat_before_delay: got %0d want 1", row_c); end
      end
      if (k == 28) begin
        total++; if (row_c !== 3'd2) begin bad++; $display("FAIL repeat_first: got %0d want 2", row_c); end
      end
      if (k == 32) begin
        total++; if (row_c !== 3'd2) begin bad++; $display("FAIL repeat_before_rate: got %0d want 2", row_c); end
      end
      if (k == 33) begin
        total++; if (row_c !== 3'd3) begin bad++; $display("FAIL repeat_second: got %0d want 3", row_c); end
      end
      if (k == 53) begin
        total++; if (row_c !== 3'd7) begin bad++; $display("FAIL repeat_reach7: got %0d want 7", row_c); end
      end
    end
    total++; if (row_c !== 3'd7) begin bad++; $display("FAIL repeat_sat: got %0d want 7", row_c); end
    total++; if (pulses != 7) begin bad++; $display("FAIL repeat_pulses: got %0d want 7", pulses); end
    btn_c = '0;
    repeat (10) tick();
    total++; if (row_c !== 3'd7) begin bad++; $display("FAIL repeat_release: got %0d want 7", row_c); end
  endtask

  task automatic test_cancel();
    int pulses = 0;
    btn_a = 4'b1011;
    repeat (30) begin tick(); if (moved_a) pulses++; end
    total++; if (row_a !== 3'd0 || col_a !== 3'd1) begin bad++; $display("FAIL cancel_pos: got row=%0d col=%0d want row=0 col=1", row_a, col_a); end
    total++; if (pulses != 1) begin bad++; $display("FAIL cancel_pulses: got %0d want 1", pulses); end
    btn_a = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int pa = 0;
    int pb = 0;
    repeat (4) press(0, 4'b1000);
    repeat (5) press(1, 4'b1000);
    total++; if (col_a !== 3'd5 || col_b !== 3'd5) begin bad++; $display("FAIL setup_col5: got %0d/%0d want 5/5", col_a, col_b); end
    total++; if (s2_a !== SEG5) begin bad++; $display("FAIL setup_seg2: got %b want %b", s2_a, SEG5); end
    btn_a = 4'b0100;
    btn_b = 4'b0100;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (col_a !== 3'd0 || col_b !== 3'd0 || row_b !== 3'd0) begin bad++; $display("FAIL midreset_clear: got colA=%0d colB=%0d rowB=%0d want 0/0/0", col_a, col_b, row_b); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (moved_a) pa++;
      if (moved_b) pb++;
      if (k == 7) begin
        total++; if (col_b !== 3'd0) begin bad++; $display("FAIL midreset_early: got %0d want 0", col_b); end
      end
      if (k == 8) begin
        total++; if (col_b !== 3'd7) begin bad++; $display("FAIL midreset_wrap: got %0d want 7", col_b); end
      end
    end
    total++; if (col_a !== 3'd0 || pa != 0) begin bad++; $display("FAIL midreset_sat: got col=%0d pulses=%0d want col=0 pulses=0", col_a, pa); end
    total++; if (pb != 1) begin bad++; $display("FAIL midreset_pulses: got %0d want 1", pb); end
    total++; if (s2_b !== SEG7) begin bad++; $display("FAIL midreset_seg2: got %b want %b", s2_b, SEG7); end
    btn_a = '0;
    btn_b = '0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_edge();
    test_repeat();
    test_cancel();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
